uart_alu_requester: RTL

UART_ALU_REQUESTER -- requirements
Module: uart_alu_requester

---
 rtl/uart_alu_pkg.sv | 22 ++
 rtl/uart_alu_interface.sv | 38 +++
 rtl/uart_alu_req_timer.sv | 36 +++
 rtl/uart_alu_requester.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU requester slice.
// Holds the default operand/opcode widths, the default response timeout and
// the requester state encoding used by uart_alu_interface and the RTL.
package uart_alu_pkg;

  localparam int unsigned DEF_N_DATA         = 8;
  localparam int unsigned DEF_NB_OPERATION   = 6;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SEND_A   = 4'd1,
    WAIT_A   = 4'd2,
    SEND_B   = 4'd3,
    WAIT_B   = 4'd4,
    SEND_OP  = 4'd5,
    WAIT_OP  = 4'd6,
    WAIT_RES = 4'd7,
    FINISH   = 4'd8
  } state_t;

endpackage

// File: rtl/uart_alu_interface.sv
// Bundle of the requester's client-side and UART-side signals.
// master: the requester (drives o_*), slave: client + uart_tx/uart_rx side.
//   i_req, i_data_a, i_data_b, i_op     transaction request and operands
//   o_tx_data, o_tx_start, i_tx_done    byte path towards uart_tx
//   i_rx_data, i_rx_done                byte path from uart_rx
//   o_busy, o_done, o_result, o_timeout status and result
interface uart_alu_interface
  import uart_alu_pkg::*;
#(
  parameter int unsigned N_DATA       = DEF_N_DATA,
  parameter int unsigned NB_OPERATION = DEF_NB_OPERATION
) ();

  logic                    i_req;
  logic [N_DATA-1:0]       i_data_a;
  logic [N_DATA-1:0]       i_data_b;
  logic [NB_OPERATION-1:0] i_op;
  logic [N_DATA-1:0]       o_tx_data;
  logic                    o_tx_start;
  logic                    i_tx_done;
  logic [N_DATA-1:0]       i_rx_data;
  logic                    i_rx_done;
  logic                    o_busy;
  logic                    o_done;
  logic [N_DATA-1:0]       o_result;
  logic                    o_timeout;

  modport master (
    input  i_req, i_data_a, i_data_b, i_op, i_tx_done, i_rx_data, i_rx_done,
    output o_tx_data, o_tx_start, o_busy, o_done, o_result, o_timeout
  );

  modport slave (
    output i_req, i_data_a, i_data_b, i_op, i_tx_done, i_rx_data, i_rx_done,
    input  o_tx_data, o_tx_start, o_busy, o_done, o_result, o_timeout
  );

endinterface

// File: rtl/uart_alu_req_timer.sv
// Response timeout counter for the requester.
// Ports: i_clk, i_rst (async active-low), i_clear (hold count at 0),
//        i_enable (count cycles), o_expired (high on the last allowed cycle).
// The count starts at 0 on the first enabled cycle; o_expired is asserted
// while the count equals TIMEOUT_CYCLES-1 and the counter is enabled.
module uart_alu_req_timer
  import uart_alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign o_expired = i_enable && (cnt_q == CNT_LAST);

  // Saturates at the last value so a late clear never sees a wrapped count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_enable && !o_expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_alu_requester.sv
// Sends operand A, operand B and the zero-extended opcode to a UART
// transmitter, then waits for the one-byte ALU result from the UART receiver.
// Ports: i_clk, i_rst (async active-low), bus (uart_alu_interface.master).
// Optional feature: define UART_ALU_REQ_TIMEOUT_EN to abort the wait for the
// result after TIMEOUT_CYCLES cycles with a one-cycle o_timeout pulse.
module uart_alu_requester
  import uart_alu_pkg::*;
#(
  parameter int unsigned N_DATA         = DEF_N_DATA,
  parameter int unsigned NB_OPERATION   = DEF_NB_OPERATION,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic               i_clk,
  input logic               i_rst,
  uart_alu_interface.master bus
);

  state_t                  state_q;
  logic [N_DATA-1:0]       b_q;
  logic [NB_OPERATION-1:0] op_q;
  logic [N_DATA-1:0]       tx_data_q;
  logic [N_DATA-1:0]       result_q;
  logic                    tx_start_q;
  logic                    busy_q;
  logic                    done_q;

`ifdef UART_ALU_REQ_TIMEOUT_EN
  logic timeout_q;
  logic expired;
  logic in_wait_res;

  assign in_wait_res = (state_q == WAIT_RES);

  uart_alu_req_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (!in_wait_res),
    .i_enable  (in_wait_res),
    .o_expired (expired)
  );

  assign bus.o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign bus.o_timeout      = 1'b0;
`endif

  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_result   = result_q;

  // Transaction FSM. Outputs are loaded on the edge that enters a state, so
  // o_tx_start is high exactly during the SEND_x cycle and o_done exactly
  // during FINISH. SEND_x never looks at i_tx_done, which drops a done that
  // coincides with the start strobe.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      result_q   <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_ALU_REQ_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_ALU_REQ_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (bus.i_req) begin
            b_q        <= bus.i_data_b;
            op_q       <= bus.i_op;
            tx_data_q  <= bus.i_data_a;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND_A;
          end
        end
        SEND_A: state_q <= WAIT_A;
        WAIT_A: begin
          if (bus.i_tx_done) begin
            tx_data_q  <= b_q;
            tx_start_q <= 1'b1;
            state_q    <= SEND_B;
          end
        end
        SEND_B: state_q <= WAIT_B;
        WAIT_B: begin
          if (bus.i_tx_done) begin
            tx_data_q  <= N_DATA'(op_q);
            tx_start_q <= 1'b1;
            state_q    <= SEND_OP;
          end
        end
        SEND_OP: state_q <= WAIT_OP;
        WAIT_OP: begin
          if (bus.i_tx_done) begin
            state_q <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          // A result byte wins over a timeout expiring in the same cycle.
          if (bus.i_rx_done) begin
            result_q <= bus.i_rx_data;
            done_q   <= 1'b1;
            state_q  <= FINISH;
          end
`ifdef UART_ALU_REQ_TIMEOUT_EN
          else if (expired) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
`endif
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
